// File: rtl/div_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_param
// Purpose  : Sequential radix-2 non-restoring integer divider for DIV/DIVU.
//            The divider works on operand magnitudes. It then applies MIPS
//            sign rules: the quotient is negated when the operand signs
//            differ, and the remainder takes the sign of the dividend.
//            It uses a start/busy/done handshake, and the results are held
//            in registers until the next completion.
// Ports    : clk_i        rising-edge clock
//            reset_n_i    asynchronous active-low reset
//            start_i      begin operation (accepted in IDLE only)
//            abort_i      synchronous cancel, wins over start
//            sign_i       1 = signed (DIV), 0 = unsigned (DIVU)
//            dividend_i   dividend, sampled on the accepted start
//            divisor_i    divisor, sampled on the accepted start
//            q_o / r_o    quotient / remainder, registered and held
//            busy_o       operation in flight
//            done_o       one-cycle completion pulse
//            dz_o         divisor was zero (held with q_o/r_o)
// Config   : DIV_ZERO_DETECT_EN - when defined, a zero divisor skips the
//            iterations and completes one edge after start with dz_o=1.
//            When undefined, dz_o is tied low and a zero divisor runs the
//            full sequence.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH:0]   rem_q, rem_d;     // signed partial remainder
  logic             neg_a_q, neg_a_d; // dividend negative (signed mode only)
  logic             neg_b_q, neg_b_d; // divisor negative (signed mode only)
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
`endif

  // Operand magnitudes at the start cycle
  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  // Datapath for one iteration and for the final fix-up
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   rem_fix;

  assign neg_a_in = sign_i & dividend_i[WIDTH-1];
  assign neg_b_in = sign_i & divisor_i[WIDTH-1];
  // The most negative value negates to itself. Read as unsigned, that is
  // its correct magnitude.
  assign mag_a_in = neg_a_in ? ('0 - dividend_i) : dividend_i;
  assign mag_b_in = neg_b_in ? ('0 - divisor_i)  : divisor_i;

  // The partial remainder always lies in [-b, b), so it fits in WIDTH+1
  // bits. The shift may overflow that width, but the following add or
  // subtract brings the value back into range modulo 2^(WIDTH+1).
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign step    = rem_q[WIDTH] ? (shifted + {1'b0, dvs_q})
                                : (shifted - {1'b0, dvs_q});
  assign rem_fix = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      zero_q  <= zero_d;
      dz_q    <= dz_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zero_d  = zero_q;
    dz_d    = dz_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          quo_d   = mag_a_in;
          dvs_d   = mag_b_in;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
`ifdef DIV_ZERO_DETECT_EN
          zero_d  = (divisor_i == '0);
          if (divisor_i == '0) begin
            // Place the magnitude in the remainder so that the normal fix-up
            // restores the original dividend as r.
            rem_d   = {1'b0, mag_a_in};
            state_d = S_FIX;
          end
`endif
        end
      end

      S_ITER: begin
        rem_d = step;
        quo_d = {quo_q[WIDTH-2:0], ~step[WIDTH]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIX: begin
        q_d     = (neg_a_q ^ neg_b_q) ? ('0 - quo_q) : quo_q;
        r_d     = neg_a_q ? ('0 - rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = zero_q;
        if (zero_q) begin
          q_d = '1;
        end
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush discards the operation. It produces no pulse, and the
    // published results stay as they were.
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      q_d     = q_q;
      r_d     = r_q;
`ifdef DIV_ZERO_DETECT_EN
      dz_d    = dz_q;
`endif
    end
  end

  assign q_o    = q_q;
  assign r_o    = r_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
`ifdef DIV_ZERO_DETECT_EN
  assign dz_o   = dz_q;
`else
  assign dz_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq_param
// Purpose  : Self-checking bench for div_seq_param (WIDTH=32). The bench
//            compares each result against an arithmetic reference model.
//            The stimulus is directed cases plus randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq_param;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  int n_checks = 0;
  int n_errors = 0;

  // Last result the model expects to be published (for hold checks)
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;

  div_seq_param #(.WIDTH(W)) u_dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .abort_i    (abort),
    .sign_i     (sgn),
    .dividend_i (dvd),
    .divisor_i  (dvs),
    .q_o        (q),
    .r_o        (r),
    .busy_o     (busy),
    .done_o     (done),
    .dz_o       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: MIPS DIV/DIVU semantics from plain arithmetic
  task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz, output int elat);
    longint sa, sb, tq, tr;
    elat = W + 1;
    edz  = 1'b0;
    if (b == '0) begin
      er = a;
      if (s && a[W-1]) eq = 1;
      else             eq = '1;
`ifdef DIV_ZERO_DETECT_EN
      eq   = '1;
      edz  = 1'b1;
      elat = 1;
`endif
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      eq = tq[W-1:0];
      er = tr[W-1:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Call at a negedge. The task returns at the negedge of the done cycle,
  // so the next call starts back-to-back. If poke_at > 0, a spurious start
  // with junk operands is presented to edge E(poke_at).
  task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int poke_at);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, lat, busy_cnt;
    ref_div(s, a, b, eq, er, edz, elat);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0; dvd = $urandom; dvs = $urandom; sgn = ~s;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= W + 10; i++) begin
      if (poke_at > 0 && i == poke_at) begin
        start = 1'b1; dvd = $urandom; dvs = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(elat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    last_q = eq; last_r = er; last_dz = edz;
  endtask

  initial begin
    int dones;
    logic         rs;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op("u100_7",    1'b0, 32'd100,        32'd7,        0);
    do_op("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        0);
    do_op("s7_-2",     1'b1, 32'd7,          32'hFFFF_FFFE, 0);
    do_op("s-7_-2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 0);
    do_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op("u_ovfops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op("u5_0",      1'b0, 32'd5,          32'd0,         0);
    do_op("s-9_0",     1'b1, 32'hFFFF_FFF7,  32'd0,         0);
    do_op("u1000_3_poke", 1'b0, 32'd1000,    32'd3,         5);

    // Abort mid-operation: no done pulse and the results are held
    sgn = 1'b0; dvd = 32'd1000; dvs = 32'd3; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk);                       // E10
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dones = 0;
    repeat (W + 4) begin
      @(posedge clk); @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_q_hold", 64'(q), 64'(last_q));
    chk("abort_r_hold", 64'(r), 64'(last_r));
    chk("abort_dz_hold", 64'(dz), 64'(last_dz));

    // Start and abort together in IDLE: abort wins
    sgn = 1'b0; dvd = 32'd50; dvs = 32'd5; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("start_abort_done", 64'(done), 64'd0);

    do_op("u9_3", 1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-operation
    sgn = 1'b0; dvd = 32'd77; dvs = 32'd4; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    repeat (14) begin @(posedge clk); @(negedge clk); end
    @(posedge clk);                       // E15
    #2 reset_n = 1'b0;
    #1;
    chk("arst_q", 64'(q), 64'd0);
    chk("arst_r", 64'(r), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("u8_2", 1'b0, 32'd8, 32'd2, 0);

    // Randomized operations, all issued back-to-back
    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (k % 9 == 4) ? 32'h8000_0000 : W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'd1;
        2:       rb = '1;
        3:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      do_op("rnd", rs, ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
